// File: rtl/pipes.sv
// Shared types, RV64I opcode/funct3 constants and the field-assembly helper
// for the instruction encoder.
package pipes;

    typedef logic [63:0] word_t;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        OpAddi, OpOri, OpAndi, OpXori, OpLd, OpJalr, OpLui, OpAuipc, OpSd, OpJal, OpBeq
    } decode_op_t;

    typedef enum logic [1:0] {
        ErrNone  = 2'b00,
        ErrRange = 2'b01,
        ErrAlign = 2'b10,
        ErrUnsup = 2'b11
    } err_code_t;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [2:0] F3Addi = 3'b000;
    localparam logic [2:0] F3Xori = 3'b100;
    localparam logic [2:0] F3Ori  = 3'b110;
    localparam logic [2:0] F3Andi = 3'b111;
    localparam logic [2:0] F3Ld   = 3'b011;
    localparam logic [2:0] F3Jalr = 3'b000;
    localparam logic [2:0] F3Sd   = 3'b011;
    localparam logic [2:0] F3Beq  = 3'b000;

    localparam u32 NopInstr = 32'h0000_0013;

    typedef struct packed {
        decode_op_t op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [31:0] imm;
        err_code_t   err;
    } s1_t;

    // Only imm[31:0] is needed to build any supported format.
    function automatic u32 encode_instr(input decode_op_t op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
        u32 w;
        w = NopInstr;
        case (op)
            OpAddi:  w = {imm[11:0], rs1, F3Addi, rd, OpcOpImm};
            OpXori:  w = {imm[11:0], rs1, F3Xori, rd, OpcOpImm};
            OpOri:   w = {imm[11:0], rs1, F3Ori, rd, OpcOpImm};
            OpAndi:  w = {imm[11:0], rs1, F3Andi, rd, OpcOpImm};
            OpLd:    w = {imm[11:0], rs1, F3Ld, rd, OpcLoad};
            OpJalr:  w = {imm[11:0], rs1, F3Jalr, rd, OpcJalr};
            OpLui:   w = {imm[31:12], rd, OpcLui};
            OpAuipc: w = {imm[31:12], rd, OpcAuipc};
            OpSd:    w = {imm[11:5], rs2, rs1, F3Sd, imm[4:0], OpcStore};
            OpJal:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
            OpBeq:   w = {imm[12], imm[10:5], rs2, rs1, F3Beq, imm[4:1], imm[11], OpcBranch};
            default: w = NopInstr;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of an immediate against the format of its op.
// Priority: unsupported op, then misalignment, then range.
module imm_range_check
    import pipes::*;
(
    input  decode_op_t op_i,
    input  word_t      imm_i,
    output err_code_t  err_code_o
);

    logic fits_i, fits_u, fits_j, fits_b;

    // A field fits when every bit above its sign bit replicates that sign bit.
    assign fits_i = (&imm_i[63:11]) | ~(|imm_i[63:11]);
    assign fits_u = (&imm_i[63:31]) | ~(|imm_i[63:31]);
    assign fits_j = (&imm_i[63:20]) | ~(|imm_i[63:20]);
    assign fits_b = (&imm_i[63:12]) | ~(|imm_i[63:12]);

    always_comb begin
        err_code_o = ErrNone;
        case (op_i)
            OpAddi, OpOri, OpAndi, OpXori, OpLd, OpJalr, OpSd: begin
                if (!fits_i) err_code_o = ErrRange;
            end
            OpLui, OpAuipc: begin
                if (imm_i[11:0] != 12'd0) err_code_o = ErrAlign;
                else if (!fits_u)         err_code_o = ErrRange;
            end
            OpJal: begin
                if (imm_i[0])     err_code_o = ErrAlign;
                else if (!fits_j) err_code_o = ErrRange;
            end
            OpBeq: begin
                if (imm_i[0])     err_code_o = ErrAlign;
                else if (!fits_b) err_code_o = ErrRange;
            end
            default: err_code_o = ErrUnsup;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV64I instruction encoder: S1 holds the request and its check
// result, S2 holds the assembled word; valid/ready on both sides.
module inst_encoder
    import pipes::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  decode_op_t           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  word_t                in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output u32                   out_instr,
    output logic                 out_err,
    output err_code_t            out_err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    err_code_t chk_err;

    imm_range_check u_imm_range_check (
        .op_i       (in_op),
        .imm_i      (in_imm),
        .err_code_o (chk_err)
    );

    logic                 s1_valid_q, s1_valid_d;
    s1_t                  s1_q, s1_d;
    logic                 s2_valid_q, s2_valid_d;
    u32                   s2_instr_q, s2_instr_d;
    err_code_t            s2_err_q, s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 s1_en, s2_en;

    assign s2_en = !s2_valid_q || out_ready;
    assign s1_en = !s1_valid_q || s2_en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.op  = in_op;
                s1_d.rd  = in_rd;
                s1_d.rs1 = in_rs1;
                s1_d.rs2 = in_rs2;
                s1_d.imm = in_imm[31:0];
                s1_d.err = chk_err;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_err_d   = s1_q.err;
                s2_instr_d = (s1_q.err == ErrNone) ?
                             encode_instr(s1_q.op, s1_q.rd, s1_q.rs1, s1_q.rs2, s1_q.imm) :
                             NopInstr;
            end
        end

        err_cnt_d = err_cnt_q;
        if (s2_valid_q && out_ready && (s2_err_q != ErrNone) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= ErrNone;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready     = !reset && (!s1_valid_q || !s2_valid_q || out_ready);
    assign out_valid    = s2_valid_q;
    assign out_instr    = s2_instr_q;
    assign out_err_code = s2_err_q;
    assign out_err      = (s2_err_q != ErrNone);
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded vectors, a stalled stream and
// mid-flight reset; a second instance with a 2-bit counter checks saturation.
module tb_inst_encoder;
    import pipes::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, out_ready;
    decode_op_t in_op;
    logic [4:0] in_rd, in_rs1, in_rs2;
    word_t      in_imm;

    logic        in_ready, out_valid, out_err;
    u32          out_instr;
    err_code_t   out_err_code;
    logic [15:0] err_count;

    logic       in_ready2, out_valid2, out_err2;
    u32         out_instr2;
    err_code_t  out_err_code2;
    logic [1:0] err_count2;

    int n_vec = 0;
    int n_miscmp = 0;

    inst_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_err      (out_err),
        .out_err_code (out_err_code),
        .err_count    (err_count)
    );

    inst_encoder #(.ERR_CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_instr    (out_instr2),
        .out_err      (out_err2),
        .out_err_code (out_err_code2),
        .err_count    (err_count2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One isolated request with out_ready high; checks the 2-cycle latency.
    task automatic send_one(input string tag, input decode_op_t op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input word_t imm,
                            input u32 exp_instr, input logic [1:0] exp_code);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, ".early"}, out_valid, 0);
        @(posedge clk); #1;
        check_eq({tag, ".valid"}, out_valid, 1);
        check_eq({tag, ".instr"}, out_instr, exp_instr);
        check_eq({tag, ".err"}, out_err, exp_code != 2'b00);
        check_eq({tag, ".code"}, out_err_code, exp_code);
        check_eq({tag, ".valid2"}, out_valid2, 1);
        check_eq({tag, ".instr2"}, out_instr2, exp_instr);
        check_eq({tag, ".err2"}, out_err2, exp_code != 2'b00);
        check_eq({tag, ".code2"}, out_err_code2, exp_code);
        check_eq({tag, ".in_ready2"}, in_ready2, 1);
        @(posedge clk); #1;
    endtask

    function automatic word_t stream_imm(input int i);
        return word_t'(i * 5 - 17);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        u32    exp_q[8];
        word_t imm_v;
        int    in_idx, out_idx;
        logic  stalled, acc;
        u32    held;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = OpAddi; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.out_instr", out_instr, 0);
        check_eq("rst.out_err", out_err, 0);
        check_eq("rst.code", out_err_code, 0);
        check_eq("rst.err_count", err_count, 0);
        check_eq("rst.in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check_eq("rst.release_ready", in_ready, 1);

        send_one("addi_m1", OpAddi, 5'd1, 5'd0, 5'd0, -64'sd1, 32'hFFF0_0093, 2'b00);
        send_one("beq_m4", OpBeq, 5'd0, 5'd1, 5'd2, -64'sd4, 32'hFE20_8EE3, 2'b00);
        send_one("beq_odd", OpBeq, 5'd0, 5'd1, 5'd2, 64'd3, NopInstr, 2'b10);
        send_one("beq_far", OpBeq, 5'd0, 5'd1, 5'd2, 64'd4096, NopInstr, 2'b01);
        send_one("jal_2k", OpJal, 5'd1, 5'd0, 5'd0, 64'd2048, 32'h0010_00EF, 2'b00);
        send_one("lui_neg", OpLui, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000,
                 32'h8000_02B7, 2'b00);
        send_one("sd_m8", OpSd, 5'd0, 5'd2, 5'd3, -64'sd8, 32'hFE31_3C23, 2'b00);
        send_one("ld_16", OpLd, 5'd5, 5'd6, 5'd0, 64'd16, 32'h0103_3283, 2'b00);
        send_one("xori_max", OpXori, 5'd10, 5'd11, 5'd0, 64'd2047, 32'h7FF5_C513, 2'b00);
        send_one("andi_ff", OpAndi, 5'd1, 5'd1, 5'd0, 64'hFF, 32'h0FF0_F093, 2'b00);
        send_one("jal_m2", OpJal, 5'd0, 5'd0, 5'd0, -64'sd2, 32'hFFFF_F06F, 2'b00);
        send_one("addi_2k", OpAddi, 5'd1, 5'd0, 5'd0, 64'd2048, NopInstr, 2'b01);
        send_one("unsup", decode_op_t'(4'd15), 5'd1, 5'd0, 5'd0, 64'd1, NopInstr, 2'b11);
        send_one("lui_low", OpLui, 5'd1, 5'd0, 5'd0, 64'h1001, NopInstr, 2'b10);
        send_one("auipc_prio", OpAuipc, 5'd1, 5'd0, 5'd0, 64'h0000_0001_0000_0001,
                 NopInstr, 2'b10);
        send_one("jal_far", OpJal, 5'd1, 5'd0, 5'd0, 64'h0010_0000, NopInstr, 2'b01);
        check_eq("errcnt.count", err_count, 7);
        check_eq("errcnt.saturate", err_count2, 3);

        // Eight back-to-back ADDIs with out_ready toggling 1,0,1,0...
        for (int i = 0; i < 8; i++) begin
            imm_v = stream_imm(i);
            exp_q[i] = {imm_v[11:0], 5'd0, 3'b000, 5'(i + 1), 7'h13};
        end
        in_idx = 0; out_idx = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid = (in_idx < 8);
            if (in_idx < 8) begin
                in_op = OpAddi; in_rd = 5'(in_idx + 1); in_rs1 = '0; in_rs2 = '0;
                in_imm = stream_imm(in_idx);
            end
            #1;
            if (stalled) begin
                check_eq("stream.hold_valid", out_valid, 1);
                check_eq("stream.hold_instr", out_instr, held);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_eq("stream.order", out_instr, exp_q[out_idx]);
                out_idx++;
            end
            stalled = out_valid && !out_ready;
            held = out_instr;
            @(posedge clk); #1;
            if (acc) in_idx++;
        end
        check_eq("stream.delivered", out_idx, 8);
        check_eq("stream.accepted", in_idx, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("stream.no_dup", out_valid, 0);
        check_eq("stream.errcnt", err_count, 7);

        // Fill both stages with errored requests, then reset mid-flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OpBeq; in_rd = '0; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_imm = 64'd3;
        @(posedge clk); #1;
        in_imm = 64'd4096;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check_eq("full.in_ready", in_ready, 0);
        check_eq("full.out_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst.out_valid", out_valid, 0);
        check_eq("midrst.err_count", err_count, 0);
        check_eq("midrst.err_count2", err_count2, 0);
        check_eq("midrst.in_ready", in_ready, 0);
        check_eq("midrst.out_instr", out_instr, 0);
        reset = 1'b0;
        #1;
        check_eq("midrst.release_ready", in_ready, 1);
        send_one("post_rst", OpAddi, 5'd1, 5'd0, 5'd0, -64'sd1, 32'hFFF0_0093, 2'b00);
        check_eq("post_rst.err_count", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
